// File: rtl/systolic_sequencer_if.sv
// Stream bundle between the host, the sequencer and the 8x8 systolic array.
//   in_*     : host row stream into the sequencer (weights first, then input rows)
//   sa_*     : sequencer <-> array pins
//   res_*    : result FIFO head out to the host
// master = sequencer side, slave = host/array side.
interface systolic_sequencer_if;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  sa_load;
    logic [63:0] sa_input_value;
    logic        sa_input_valid;
    logic        sa_float;
    logic [63:0] sa_output_value;
    logic        sa_output_valid;
    logic        sa_overflow;
    logic [63:0] res_data;
    logic        res_valid;
    logic        res_ready;

    modport master (
        input  in_data, in_valid, sa_output_value, sa_output_valid, sa_overflow, res_ready,
        output in_ready, sa_load, sa_input_value, sa_input_valid, sa_float, res_data, res_valid
    );

    modport slave (
        output in_data, in_valid, sa_output_value, sa_output_valid, sa_overflow, res_ready,
        input  in_ready, sa_load, sa_input_value, sa_input_valid, sa_float, res_data, res_valid
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Host-side driver for the 8x8 systolic array. Loads 8 weight beats column by
// column, then streams input rows into the array, issuing a row only when a
// result FIFO slot is reserved for it (the array cannot stall).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle job start (ignored while busy)
//   float_mode        job number format, latched on start
//   num_rows          input rows in the job, latched on start
//   busy, done        job in progress / one-cycle end-of-job pulse
//   err_overflow      sticky array overflow for the current job
//   bus               in_*, sa_* and res_* streams (master side)
module systolic_sequencer #(
    parameter int DEPTH = 16,
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             float_mode,
    input  logic [ROW_W-1:0] num_rows,
    output logic             busy,
    output logic             done,
    output logic             err_overflow,
    systolic_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE_S} state_t;

    state_t           state, state_nxt;
    logic [ROW_W-1:0] rows_left;
    logic [2:0]       wcnt;
    logic             float_q;
    logic             err_q;
    logic [63:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_count, inflight;
    logic [7:0]       load_q;
    logic [63:0]      value_q;
    logic             ivalid_q;
    logic             in_ready;
    logic             accept, issue, push, pop, credit_ok;

    // A row may issue only if its result is guaranteed a FIFO slot: every
    // row already in the array plus every stored result holds one slot.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign accept    = bus.in_valid && in_ready;
    assign issue     = accept && (state == STREAM);
    // Results with nothing in flight are stale/spurious and dropped.
    assign push      = bus.sa_output_valid && (inflight != '0);
    assign pop       = bus.res_ready && (fifo_count != '0);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE:   if (start) state_nxt = LOAD_W;
            LOAD_W: begin
                in_ready = 1'b1;
                if (bus.in_valid && wcnt == 3'd7)
                    state_nxt = (rows_left == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                in_ready = (rows_left != '0) && credit_ok;
                if (in_ready && bus.in_valid && rows_left == ROW_W'(1))
                    state_nxt = DRAIN;
            end
            DRAIN:  if (inflight == '0) state_nxt = DONE_S;
            DONE_S: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rows_left  <= '0;
            wcnt       <= '0;
            float_q    <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
            load_q     <= '0;
            value_q    <= '0;
            ivalid_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                rows_left <= num_rows;
                float_q   <= float_mode;
                wcnt      <= '0;
            end
            if (accept && state == LOAD_W) wcnt <= wcnt + 3'd1;
            if (issue) rows_left <= rows_left - 1'b1;

            if (state == IDLE && start) err_q <= 1'b0;
            else if (busy)              err_q <= err_q | bus.sa_overflow;

            // sa_* are pulses for one cycle after the accepting edge; the
            // data bus keeps its last value.
            load_q   <= (accept && state == LOAD_W) ? (8'b1 << wcnt) : 8'b0;
            ivalid_q <= issue;
            if (accept) value_q <= bus.in_data;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            inflight   <= inflight + CW'(issue) - CW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.sa_output_value;
    end

    assign busy               = (state == LOAD_W) || (state == STREAM) || (state == DRAIN);
    assign done               = (state == DONE_S);
    assign err_overflow       = err_q;
    assign bus.in_ready       = in_ready;
    assign bus.sa_load        = load_q;
    assign bus.sa_input_value = value_q;
    assign bus.sa_input_valid = ivalid_q;
    assign bus.sa_float       = float_q;
    assign bus.res_data       = mem[rd_ptr];
    assign bus.res_valid      = (fifo_count != '0);
endmodule
